region_mux: RTL and testbench

//  Parametrised N-way successor to the two-way mem/MMIO split. Decodes a single upstream bus

---
 rtl/region_mux.sv | 137 +++++++++++++
 tb/tb_region_mux.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/region_mux.sv
// N-way region decoder between the upstream bus and N_SLV slaves. It tracks one outstanding
// request, times out hung slaves, and answers unmapped or aborted accesses with ERR_DATA.

module region_mux_lane #(
    parameter logic [31:0] BASE_I = 32'h0,
    parameter logic [31:0] MASK_I = 32'h0
) (
    input  logic [31:0] a,
    output logic        hit
);
    assign hit = ((a & MASK_I) == BASE_I);
endmodule

module region_mux #(
    parameter int                  N_SLV    = 4,
    parameter logic [N_SLV*32-1:0] BASE     = {N_SLV{32'h0}},
    parameter logic [N_SLV*32-1:0] MASK     = {N_SLV{32'h0}},
    parameter int                  TIMEOUT  = 1023,
    parameter logic [31:0]         ERR_DATA = 32'hdeadbeef
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           a,
    input  logic [31:0]           d,
    input  logic                  we,
    input  logic                  rd,
    output logic [31:0]           spo,
    output logic                  ready,
    output logic [N_SLV*32-1:0]   s_a,
    output logic [N_SLV*32-1:0]   s_d,
    output logic [N_SLV-1:0]      s_we,
    output logic [N_SLV-1:0]      s_rd,
    input  logic [N_SLV*32-1:0]   s_spo,
    input  logic [N_SLV-1:0]      s_ready,
    output logic                  bus_err,
    output logic [31:0]           err_addr
);
    localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

    state_t            state;
    logic [31:0]       a_q, d_q;
    logic              rd_q;
    logic [SW-1:0]     sel_q, sel_d;
    logic [TW-1:0]     timer;
    logic [N_SLV-1:0]  hit, sel_oh;
    logic              rd_only;

    for (genvar i = 0; i < N_SLV; i++) begin : g_lane
        region_mux_lane #(
            .BASE_I(BASE[32*i +: 32]),
            .MASK_I(MASK[32*i +: 32])
        ) u_lane (
            .a  (a),
            .hit(hit[i])
        );
    end

    // Scan downward so the lowest hitting slot wins on overlap.
    always_comb begin
        sel_d = '0;
        for (int i = N_SLV - 1; i >= 0; i--)
            if (hit[i]) sel_d = SW'(i);
    end

    assign sel_oh  = N_SLV'(1) << sel_d;
    assign rd_only = rd & ~we;
    assign s_a     = {N_SLV{a_q}};
    assign s_d     = {N_SLV{d_q}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            spo      <= '0;
            s_we     <= '0;
            s_rd     <= '0;
            a_q      <= '0;
            d_q      <= '0;
            rd_q     <= 1'b0;
            sel_q    <= '0;
            timer    <= '0;
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else begin
            bus_err <= 1'b0;
            s_we    <= '0;
            s_rd    <= '0;
            case (state)
                IDLE: if (we | rd) begin
                    a_q   <= a;
                    d_q   <= d;
                    rd_q  <= rd_only;
                    sel_q <= sel_d;
                    ready <= 1'b0;
                    if (|hit) begin
                        // Strobes go out during the ISSUE cycle.
                        s_we  <= we ? sel_oh : '0;
                        s_rd  <= rd_only ? sel_oh : '0;
                        state <= ISSUE;
                    end else begin
                        state <= ERR;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (s_ready[sel_q]) begin
                        spo   <= rd_q ? s_spo[32*sel_q +: 32] : 32'h0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end else if (TIMEOUT != 0 && timer == TW'(TIMEOUT - 1)) begin
                        spo      <= ERR_DATA;
                        ready    <= 1'b1;
                        bus_err  <= 1'b1;
                        err_addr <= a_q;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ERR: begin
                    spo      <= rd_q ? ERR_DATA : 32'h0;
                    bus_err  <= 1'b1;
                    err_addr <= a_q;
                    ready    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_region_mux.sv
// Directed bench for region_mux: vector table of single transactions plus reset corner cases.

module tb_region_mux;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     a, d;
    logic            we, rd;
    logic [31:0]     spo;
    logic            ready;
    logic [N*32-1:0] s_a, s_d, s_spo;
    logic [N-1:0]    s_we, s_rd, s_ready;
    logic            bus_err;
    logic [31:0]     err_addr;

    int checks = 0;
    int errors = 0;

    region_mux #(
        .N_SLV   (N),
        .BASE    ({32'hA000_0000, 32'h9000_0000, 32'h8000_0000, 32'h8000_0000}),
        .MASK    ({32'hF000_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000}),
        .TIMEOUT (8),
        .ERR_DATA(32'hdeadbeef)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd),
        .spo(spo), .ready(ready), .s_a(s_a), .s_d(s_d),
        .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready),
        .bus_err(bus_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we, rd;
        logic [31:0] a, d;
        int          slot;   // -1 = unmapped
        int          k;      // WAIT cycle in which slave goes ready; 0 = hang
        logic [31:0] sdata;
        logic [3:0]  we_m, rd_m;
        logic [31:0] spo;
        int          lat;
        logic        err;
        logic [31:0] ea;
        logic        viol;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int n = 0, lat = -1, errs = 0, err_n = 0, stb = 0;
        logic [3:0] we_acc = '0, rd_acc = '0;
        @(negedge clk);
        a = v.a; d = v.d; we = v.we; rd = v.rd; s_ready = '0;
        for (int i = 0; i < N; i++) s_spo[32*i +: 32] = (i == v.slot) ? v.sdata : ~v.sdata;
        while (lat < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin we = 1'b0; rd = 1'b0; end
            if (v.viol && n == 2) begin we = 1'b1; a = 32'h5000_0000; d = 32'h0; end
            if (v.viol && n == 3) we = 1'b0;
            we_acc |= s_we;
            rd_acc |= s_rd;
            stb += $countones({s_we, s_rd});
            if (bus_err) begin errs++; err_n = n; end
            if (ready) lat = n;
            if (v.k > 0 && n == 1 + v.k) s_ready[v.slot] = 1'b1;
        end
        chk("latency", lat, v.lat);
        chk("spo", spo, v.spo);
        chk("we_mask", 32'(we_acc), 32'(v.we_m));
        chk("rd_mask", 32'(rd_acc), 32'(v.rd_m));
        chk("strobe_cnt", stb, (v.slot >= 0) ? 1 : 0);
        chk("bus_err_cnt", errs, 32'(v.err));
        chk("bus_err_cycle", err_n, v.err ? v.lat : 0);
        chk("err_addr", err_addr, v.ea);
        chk("s_a", s_a[127:96], v.a);
        chk("s_d", s_d[31:0], v.d);
        // Late slave ready must not disturb the completed result.
        s_ready = '1;
        a = v.a; d = v.d;
        repeat (2) begin
            @(negedge clk);
            chk("idle_ready", 32'(ready), 32'h1);
            chk("idle_no_err", 32'(bus_err), 32'h0);
            chk("idle_spo", spo, v.spo);
            chk("idle_no_stb", 32'({s_we, s_rd}), 32'h0);
        end
    endtask

    initial begin
        //       we    rd    a              d              slot k  sdata          we_m     rd_m     spo            lat err   ea             viol
        tv[0] = '{1'b0, 1'b1, 32'h9000_0010, 32'h0000_00A1, 2,  3, 32'h1234_5678, 4'b0000, 4'b0100, 32'h1234_5678, 5,  1'b0, 32'h0,          1'b0};
        tv[1] = '{1'b1, 1'b0, 32'h8000_0000, 32'hCAFE_0001, 0,  1, 32'h5555_5555, 4'b0001, 4'b0000, 32'h0,          3,  1'b0, 32'h0,          1'b0};
        tv[2] = '{1'b0, 1'b1, 32'h5000_0000, 32'h0000_00A2, -1, 0, 32'h0,          4'b0000, 4'b0000, 32'hdeadbeef, 2,  1'b1, 32'h5000_0000, 1'b0};
        tv[3] = '{1'b1, 1'b0, 32'h5000_0004, 32'h0000_00A3, -1, 0, 32'h0,          4'b0000, 4'b0000, 32'h0,          2,  1'b1, 32'h5000_0004, 1'b0};
        tv[4] = '{1'b0, 1'b1, 32'hA000_0040, 32'h0000_00A4, 3,  0, 32'h3333_3333, 4'b0000, 4'b1000, 32'hdeadbeef, 10, 1'b1, 32'hA000_0040, 1'b0};
        tv[5] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0000_00A5, 0,  2, 32'h0BAD_F00D, 4'b0000, 4'b0001, 32'h0BAD_F00D, 4,  1'b0, 32'hA000_0040, 1'b0};
        tv[6] = '{1'b1, 1'b1, 32'h8100_0000, 32'h1111_2222, 0,  1, 32'h4444_4444, 4'b0001, 4'b0000, 32'h0,          3,  1'b0, 32'hA000_0040, 1'b0};
        tv[7] = '{1'b0, 1'b1, 32'h8FFF_FFFC, 32'h0000_00A7, 0,  1, 32'h7777_0001, 4'b0000, 4'b0001, 32'h7777_0001, 3,  1'b0, 32'hA000_0040, 1'b0};
        tv[8] = '{1'b0, 1'b1, 32'h9000_0010, 32'h0000_00A8, 2,  3, 32'h1234_5678, 4'b0000, 4'b0100, 32'h1234_5678, 5,  1'b0, 32'hA000_0040, 1'b1};

        rst = 1'b1; a = '0; d = '0; we = 1'b0; rd = 1'b0; s_ready = '1; s_spo = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_stb", 32'({s_we, s_rd}), 32'h0);
        chk("rst_spo", spo, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_s_a", s_a[31:0], 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_txn(tv[i]);

        // Reset while waiting on a hung slave drops the transaction silently.
        @(negedge clk);
        a = 32'hA000_0000; rd = 1'b1; s_ready = '0;
        @(negedge clk); rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wait_ready_low", 32'(ready), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(ready), 32'h1);
        chk("mid_rst_bus_err", 32'(bus_err), 32'h0);
        chk("mid_rst_err_addr", err_addr, 32'h0);
        chk("mid_rst_spo", spo, 32'h0);
        rst = 1'b0;
        begin
            int late_err = 0, not_ready = 0;
            repeat (12) begin
                @(negedge clk);
                if (bus_err) late_err++;
                if (!ready) not_ready++;
            end
            chk("post_rst_no_err", late_err, 0);
            chk("post_rst_idle", not_ready, 0);
        end
        s_ready = '1;
        run_txn(tv[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
